// File: rtl/csr_bus_pkg.sv
// ============================================================================
// Module : csr_bus_pkg
// Brief  : Shared encodings and helpers for the 3-stage CSR responder bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_bus_pkg;

  localparam logic [2:0]  MOD_NONE          = 3'b000;
  localparam logic [2:0]  MOD_WRITE         = 3'b001;
  localparam logic [2:0]  MOD_SET           = 3'b010;
  localparam logic [2:0]  MOD_CLEAR         = 3'b011;
  localparam logic [11:0] DEFAULT_IDLE_ADDR = 12'h000;
  localparam logic [1:0]  RO_ADDR_PREFIX    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  // A modifying access to the read-only address quadrant.
  function automatic logic ro_fault(input logic write, input logic [11:0] addr,
                                    input logic [1:0] op);
    return write && (addr[11:10] == RO_ADDR_PREFIX) && (op != 2'b00);
  endfunction

  function automatic logic [2:0] op_to_modify(input logic [1:0] op);
    case (op)
      2'b01:   return MOD_WRITE;
      2'b10:   return MOD_SET;
      2'b11:   return MOD_CLEAR;
      default: return MOD_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_initiator_if.sv
// ============================================================================
// Module : csr_initiator_if
// Brief  : Request/response channels plus CSR responder bus of the initiator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_initiator_if #(
  parameter int NUM_RESP = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic [11:0]               req_addr;
  logic [1:0]                req_op;
  logic                      req_write;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic [11:0]               csr_addr;
  logic                      csr_read;
  logic [2:0]                csr_modify;
  logic [31:0]               csr_wdata;
  logic [32*NUM_RESP-1:0]    csr_rdata_bus;
  logic [NUM_RESP-1:0]       csr_valid_bus;

  modport master (
    input  req_valid, req_addr, req_op, req_write, req_wdata, rsp_ready,
           csr_rdata_bus, csr_valid_bus,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_addr, csr_read, csr_modify, csr_wdata
  );

  modport slave (
    output req_valid, req_addr, req_op, req_write, req_wdata, rsp_ready,
           csr_rdata_bus, csr_valid_bus,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_addr, csr_read, csr_modify, csr_wdata
  );
endinterface

`default_nettype wire

// File: rtl/csr_resp_merge.sv
// ============================================================================
// Module : csr_resp_merge
// Brief  : OR-merges responder read data and classifies the valid vector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_resp_merge #(
  parameter int NUM_RESP = 4
) (
  input  wire logic [32*NUM_RESP-1:0] rdata_bus,
  input  wire logic [NUM_RESP-1:0]    valid_bus,
  output logic      [31:0]            rdata_or,
  output logic                        any_valid,
  output logic                        multi_valid
);

  logic [31:0] w_slice [NUM_RESP];

  for (genvar gi = 0; gi < NUM_RESP; gi++) begin : g_slice
    assign w_slice[gi] = rdata_bus[32*gi +: 32];
  end

  always_comb begin
    rdata_or    = '0;
    any_valid   = 1'b0;
    multi_valid = 1'b0;
    for (int i = 0; i < NUM_RESP; i++) begin
      rdata_or = rdata_or | w_slice[i];
      if (valid_bus[i]) begin
        multi_valid = multi_valid | any_valid;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/csr_initiator.sv
// ============================================================================
// Module : csr_initiator
// Brief  : Sequences one CSR access over the D/E/M responder bus and returns
//          the pre-modification value with an error flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_initiator
  import csr_bus_pkg::*;
#(
  parameter int          NUM_RESP  = 4,
  parameter logic [11:0] IDLE_ADDR = DEFAULT_IDLE_ADDR
) (
  input wire logic       clk,
  input wire logic       rstn,
  csr_initiator_if.master bus
);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_mod, w_mod_nxt;
  logic        r_rofault, w_rofault_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [11:0] r_csr_addr, w_csr_addr_nxt;
  logic        r_csr_read, w_csr_read_nxt;
  logic [2:0]  r_csr_modify, w_csr_modify_nxt;
  logic [31:0] r_csr_wdata, w_csr_wdata_nxt;

  logic [31:0] w_rdata_or;
  logic        w_any_valid;
  logic        w_multi_valid;
  logic        w_accept_rofault;

  csr_resp_merge #(.NUM_RESP(NUM_RESP)) u_merge (
    .rdata_bus   (bus.csr_rdata_bus),
    .valid_bus   (bus.csr_valid_bus),
    .rdata_or    (w_rdata_or),
    .any_valid   (w_any_valid),
    .multi_valid (w_multi_valid)
  );

  assign w_accept_rofault = ro_fault(bus.req_write, bus.req_addr, bus.req_op);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_mod        <= MOD_NONE;
      r_rofault    <= 1'b0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_csr_addr   <= IDLE_ADDR;
      r_csr_read   <= 1'b0;
      r_csr_modify <= MOD_NONE;
      r_csr_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mod        <= w_mod_nxt;
      r_rofault    <= w_rofault_nxt;
      r_wdata      <= w_wdata_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_csr_addr   <= w_csr_addr_nxt;
      r_csr_read   <= w_csr_read_nxt;
      r_csr_modify <= w_csr_modify_nxt;
      r_csr_wdata  <= w_csr_wdata_nxt;
    end
  end

  // Each branch computes the value the registered outputs take in the next state.
  always_comb begin
    w_state_nxt      = r_state;
    w_mod_nxt        = r_mod;
    w_rofault_nxt    = r_rofault;
    w_wdata_nxt      = r_wdata;
    w_req_ready_nxt  = 1'b0;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_err_nxt    = r_rsp_err;
    w_csr_addr_nxt   = IDLE_ADDR;
    w_csr_read_nxt   = 1'b0;
    w_csr_modify_nxt = MOD_NONE;
    w_csr_wdata_nxt  = '0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (r_req_ready && bus.req_valid) begin
          w_req_ready_nxt = 1'b0;
          w_rofault_nxt   = w_accept_rofault;
          w_mod_nxt       = (bus.req_write && !w_accept_rofault)
                            ? op_to_modify(bus.req_op) : MOD_NONE;
          w_wdata_nxt     = bus.req_wdata;
          w_csr_addr_nxt  = bus.req_addr;
          w_state_nxt     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_csr_read_nxt   = 1'b1;
        w_csr_modify_nxt = r_mod;
        w_csr_wdata_nxt  = r_wdata;
        w_state_nxt      = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = w_any_valid ? w_rdata_or : 32'h0;
        w_rsp_err_nxt   = !w_any_valid || w_multi_valid || r_rofault;
        w_state_nxt     = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.csr_addr   = r_csr_addr;
  assign bus.csr_read   = r_csr_read;
  assign bus.csr_modify = r_csr_modify;
  assign bus.csr_wdata  = r_csr_wdata;

endmodule

`default_nettype wire

// File: tb/tb_csr_initiator.sv
// ============================================================================
// Module : tb_csr_initiator
// Brief  : Directed bench for csr_initiator with four modelled CSR responders.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_initiator;

  localparam logic [31:0] KHZ      = 32'h0001_86A0;
  localparam logic [31:0] VENDORID = 32'h0000_0A5C;
  localparam logic [31:0] SPARE    = 32'h0000_F000;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  csr_initiator_if #(.NUM_RESP(4)) bus ();

  csr_initiator #(.NUM_RESP(4), .IDLE_ADDR(12'h000)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Responders: enable registered from csr_addr, read+modify on the E-stage edge.
  logic [3:0]  sel     = '0;
  logic [3:0]  rvld    = '0;
  logic [31:0] rdat [4];
  logic [31:0] pins    = '0;
  logic        dup_en  = 1'b0;
  int          mod_count = 0;

  initial for (int i = 0; i < 4; i++) rdat[i] = '0;

  assign bus.csr_rdata_bus = {rdat[3], rdat[2], rdat[1], rdat[0]};
  assign bus.csr_valid_bus = rvld;

  always @(posedge clk) begin
    sel[0] <= (bus.csr_addr == 12'hFC0);
    sel[1] <= (bus.csr_addr == 12'hBC1);
    sel[2] <= (bus.csr_addr == 12'hF11);
    sel[3] <= dup_en && (bus.csr_addr == 12'hBC1);
    for (int i = 0; i < 4; i++) begin
      rvld[i] <= bus.csr_read && sel[i];
      rdat[i] <= '0;
    end
    if (bus.csr_read && sel[0]) rdat[0] <= KHZ;
    if (bus.csr_read && sel[1]) rdat[1] <= pins;
    if (bus.csr_read && sel[2]) rdat[2] <= VENDORID;
    if (bus.csr_read && sel[3]) rdat[3] <= SPARE;
    if (bus.csr_read && sel[1]) begin
      case (bus.csr_modify)
        3'b001:  pins <= bus.csr_wdata;
        3'b010:  pins <= pins | bus.csr_wdata;
        3'b011:  pins <= pins & ~bus.csr_wdata;
        default: pins <= pins;
      endcase
    end
    if (bus.csr_modify != 3'b000) mod_count <= mod_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake
  // (or at the negedge where rsp_valid is first seen if rsp_ready is low).
  task automatic do_access(input logic [11:0] addr, input logic [1:0] op,
                           input logic wr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic [11:0] d_addr, output logic x_read,
                           output logic [2:0] x_mod);
    int k;
    rd = '0; er = 1'b0; lat = -1; d_addr = '0; x_read = 1'b0; x_mod = '0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_op    = op;
    bus.req_write = wr;
    bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) d_addr = bus.csr_addr;
      if (c == 2) begin
        x_read = bus.csr_read;
        x_mod  = bus.csr_modify;
      end
      if (bus.rsp_valid) begin
        lat = c;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
    else if (bus.rsp_ready) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
    check({tag, "_csr_addr"}, {20'd0, bus.csr_addr}, 32'd0);
    check({tag, "_csr_read"}, {31'd0, bus.csr_read}, 32'd0);
    check({tag, "_csr_modify"}, {29'd0, bus.csr_modify}, 32'd0);
    check({tag, "_csr_wdata"}, bus.csr_wdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er, x_read;
  logic [11:0] d_addr;
  logic [2:0]  x_mod;
  int          lat, mc;

  initial begin
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_op = '0;
    bus.req_write = 1'b0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);

    // Plain read of the KHz CSR
    mc = mod_count;
    do_access(12'hFC0, 2'b00, 1'b0, 32'h0, rd, er, lat, d_addr, x_read, x_mod);
    check("khz_rdata", rd, KHZ);
    check("khz_err", {31'd0, er}, 32'd0);
    check("khz_latency", lat, 32'd4);
    check("khz_dec_addr", {20'd0, d_addr}, 32'h0FC0);
    check("khz_exec_read", {31'd0, x_read}, 32'd1);
    check("khz_no_modify", mod_count, mc);
    check("khz_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("idle_csr_addr", {20'd0, bus.csr_addr}, 32'd0);

    // Pin register: write / set / clear, each returning the prior value
    do_access(12'hBC1, 2'b01, 1'b1, 32'h5, rd, er, lat, d_addr, x_read, x_mod);
    check("pin_wr_rdata", rd, 32'h0);
    check("pin_wr_mod", {29'd0, x_mod}, 32'd1);
    check("pin_wr_err", {31'd0, er}, 32'd0);
    do_access(12'hBC1, 2'b10, 1'b1, 32'h8, rd, er, lat, d_addr, x_read, x_mod);
    check("pin_set_rdata", rd, 32'h5);
    check("pin_set_mod", {29'd0, x_mod}, 32'd2);
    do_access(12'hBC1, 2'b11, 1'b1, 32'h1, rd, er, lat, d_addr, x_read, x_mod);
    check("pin_clr_rdata", rd, 32'hD);
    check("pin_clr_mod", {29'd0, x_mod}, 32'd3);
    check("pin_value", pins, 32'hC);

    // op=00 with write=1 is a pure read without error
    do_access(12'hBC1, 2'b00, 1'b1, 32'hFF, rd, er, lat, d_addr, x_read, x_mod);
    check("op00_rdata", rd, 32'hC);
    check("op00_mod", {29'd0, x_mod}, 32'd0);
    check("op00_err", {31'd0, er}, 32'd0);
    check("op00_pins", pins, 32'hC);

    // Unmapped address
    do_access(12'h123, 2'b00, 1'b0, 32'h0, rd, er, lat, d_addr, x_read, x_mod);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_err", {31'd0, er}, 32'd1);

    // Two responders answering the same address
    dup_en = 1'b1;
    do_access(12'hBC1, 2'b00, 1'b0, 32'h0, rd, er, lat, d_addr, x_read, x_mod);
    dup_en = 1'b0;
    check("dup_rdata", rd, 32'h0000_F00C);
    check("dup_err", {31'd0, er}, 32'd1);

    // Write to the read-only quadrant: read happens, no modify, error
    mc = mod_count;
    do_access(12'hF11, 2'b01, 1'b1, 32'hFFFF, rd, er, lat, d_addr, x_read, x_mod);
    check("ro_rdata", rd, VENDORID);
    check("ro_err", {31'd0, er}, 32'd1);
    check("ro_mod", {29'd0, x_mod}, 32'd0);
    check("ro_read", {31'd0, x_read}, 32'd1);
    check("ro_no_modify", mod_count, mc);
    do_access(12'hF11, 2'b00, 1'b1, 32'hFFFF, rd, er, lat, d_addr, x_read, x_mod);
    check("ro_op00_err", {31'd0, er}, 32'd0);

    // Backpressure with a competing request offered while the response waits
    bus.rsp_ready = 1'b0;
    mc = mod_count;
    do_access(12'hFC0, 2'b00, 1'b0, 32'h0, rd, er, lat, d_addr, x_read, x_mod);
    check("bp_latency", lat, 32'd4);
    bus.req_valid = 1'b1; bus.req_addr = 12'hBC1; bus.req_op = 2'b01;
    bus.req_write = 1'b1; bus.req_wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_rdata", bus.rsp_rdata, KHZ);
      check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("bp_csr_addr", {20'd0, bus.csr_addr}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp_no_modify", mod_count, mc);
    check("bp_pins", pins, 32'hC);

    // Reset asserted while a write is in its E stage
    bus.req_valid = 1'b1; bus.req_addr = 12'hBC1; bus.req_op = 2'b01;
    bus.req_write = 1'b1; bus.req_wdata = 32'h3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_exec_mod", {29'd0, bus.csr_modify}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    mc = mod_count;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_modify", mod_count, mc);
    do_access(12'hBC1, 2'b00, 1'b0, 32'h0, rd, er, lat, d_addr, x_read, x_mod);
    check("post_rst_rdata", rd, 32'h3);
    check("post_rst_err", {31'd0, er}, 32'd0);
    check("post_rst_latency", lat, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
